// File: rtl/uart_rx.sv
// Purpose : 8N1 UART receiver; recovers bytes from an async serial line, LSB first.
// Latency : done/frame_error one cycle after the mid-stop-bit sample (2-flop sync adds 2 cycles).
// Backpr. : none; readdata holds until the next good frame and must be captured on done.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   rx          serial input, idle high, asynchronous to clock
//   readdata    last correctly received byte
//   done        one-cycle pulse when readdata is updated
//   frame_error one-cycle pulse when the stop bit samples 0
//   active      high while a frame is in START/DATA/STOP
module uart_rx #(
    parameter int uart_clock_bit = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] readdata,
    output logic       done,
    output logic       frame_error,
    output logic       active
);

    localparam int HALF = (uart_clock_bit - 1) / 2;
    localparam int CW   = $clog2(uart_clock_bit);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(uart_clock_bit - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cyc_cnt, cyc_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [7:0]    readdata_nxt;
    logic          done_nxt, ferr_nxt, active_nxt;
    logic          rx_meta, rx_sync;

    // Two-flop synchronizer; reset to the idle level so no false start is seen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_comb begin
        state_nxt    = state;
        cyc_nxt      = cyc_cnt;
        bit_nxt      = bit_cnt;
        shift_nxt    = shift;
        readdata_nxt = readdata;
        done_nxt     = 1'b0;
        ferr_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                cyc_nxt = '0;
                bit_nxt = '0;
                if (!rx_sync) state_nxt = S_START;
            end
            S_START: begin
                // Mid start bit: a line back high means it was only a glitch.
                if (cyc_cnt == HALF_LAST) begin
                    cyc_nxt   = '0;
                    state_nxt = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    cyc_nxt = cyc_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (cyc_cnt == BIT_LAST) begin
                    cyc_nxt   = '0;
                    // Shift in from the MSB so the first (LSB) bit lands in bit 0.
                    shift_nxt = {rx_sync, shift[7:1]};
                    bit_nxt   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = S_STOP;
                end else begin
                    cyc_nxt = cyc_cnt + CW'(1);
                end
            end
            S_STOP: begin
                // Return to IDLE at mid stop bit so an immediately following start is caught.
                if (cyc_cnt == BIT_LAST) begin
                    cyc_nxt = '0;
                    if (rx_sync) begin
                        readdata_nxt = shift;
                        done_nxt     = 1'b1;
                        state_nxt    = S_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end else begin
                    cyc_nxt = cyc_cnt + CW'(1);
                end
            end
            S_BREAK: begin
                // Wait for the line to recover so a held-low line cannot retrigger.
                cyc_nxt = '0;
                if (rx_sync) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        active_nxt = (state_nxt == S_START) || (state_nxt == S_DATA) || (state_nxt == S_STOP);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cyc_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            readdata    <= '0;
            done        <= 1'b0;
            frame_error <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cyc_cnt     <= cyc_nxt;
            bit_cnt     <= bit_nxt;
            shift       <= shift_nxt;
            readdata    <= readdata_nxt;
            done        <= done_nxt;
            frame_error <= ferr_nxt;
            active      <= active_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Purpose : self-checking bench for uart_rx (vector table, corner sequences, random frames).
// Latency : n/a.
// Backpr. : n/a.
module tb_uart_rx;

    localparam int UCB  = 32;
    localparam int HALF = (UCB - 1) / 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] readdata;
    logic       done, frame_error, active;

    uart_rx #(.uart_clock_bit(UCB)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .readdata    (readdata),
        .done        (done),
        .frame_error (frame_error),
        .active      (active)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         err;
        logic [7:0] rd;
        int         t;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    int  both_high = 0;
    int  tests = 0;
    int  failed = 0;

    // Event monitor: every done/frame_error pulse with the readdata seen alongside it.
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (done || frame_error) begin
            ev_t e;
            e.err = frame_error;
            e.rd  = readdata;
            e.t   = cyc;
            evq.push_back(e);
        end
        if (done && frame_error) both_high <= both_high + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one 8N1 frame with the given bit period; counts mid-bit samples
    // (start + data bits) where active was unexpectedly low.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int per, output int miss);
        logic [9:0] bits;
        bits = {stop_ok, d, 1'b0};
        miss = 0;
        for (int b = 0; b < 10; b++) begin
            rx = bits[b];
            for (int c = 0; c < per; c++) begin
                @(negedge clock);
                if (b < 9 && c == per / 2 && !active) miss++;
            end
        end
    endtask

    // Sends one frame, optionally holds the line low afterwards (break) and/or idles,
    // then expects exactly one event of the given kind with the given readdata.
    task automatic apply(input string name, input logic [7:0] d, input bit stop_ok, input int per,
                         input int hold, input int gap, input logic [7:0] exp_rd, input bit exp_err);
        int miss;
        int act_hold;
        evq.delete();
        send_frame(d, stop_ok, per, miss);
        act_hold = 0;
        if (hold > 0) begin
            rx = 1'b0;
            for (int c = 0; c < hold; c++) begin
                @(negedge clock);
                if (active) act_hold++;
            end
            rx = 1'b1;
            repeat (UCB) @(negedge clock);
        end
        rx = 1'b1;
        repeat (gap) @(negedge clock);
        check({name, "_events"}, evq.size(), 1);
        if (evq.size() > 0) begin
            check({name, "_kind"}, evq[0].err, exp_err);
            check({name, "_readdata"}, evq[0].rd, exp_rd);
        end
        check({name, "_active_in_frame"}, miss, 0);
        if (hold > 0) check({name, "_active_in_break"}, act_hold, 0);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         per;
        int         hold;
        logic [7:0] exp_rd;
        bit         exp_err;
    } vec_t;

    initial begin
        vec_t       vecs[10];
        logic [7:0] last_good;
        int         n_act;
        int         miss;
        int         dt;

        vecs[0] = '{8'hAA, 1'b1, UCB,     0,    8'hAA, 1'b0};
        vecs[1] = '{8'hAB, 1'b1, UCB,     0,    8'hAB, 1'b0};
        vecs[2] = '{8'hAC, 1'b1, UCB,     0,    8'hAC, 1'b0};
        vecs[3] = '{8'hAD, 1'b1, UCB,     0,    8'hAD, 1'b0};
        vecs[4] = '{8'hAF, 1'b1, UCB,     0,    8'hAF, 1'b0};
        vecs[5] = '{8'h3C, 1'b0, UCB,     2000, 8'hAF, 1'b1};
        vecs[6] = '{8'h81, 1'b1, UCB,     0,    8'h81, 1'b0};
        vecs[7] = '{8'h96, 1'b1, UCB + 1, 0,    8'h96, 1'b0};
        vecs[8] = '{8'h69, 1'b1, UCB - 1, 0,    8'h69, 1'b0};
        vecs[9] = '{8'h96, 1'b1, UCB - 1, 0,    8'h96, 1'b0};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_readdata", readdata, 0);
        check("rst_done", done, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_active", active, 0);
        reset = 1'b1;
        repeat (UCB) @(negedge clock);

        // Vector table: back-to-back loopback bytes, break, recovery, bit-period skew
        for (int i = 0; i < 10; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop_ok, vecs[i].per,
                  vecs[i].hold, 0, vecs[i].exp_rd, vecs[i].exp_err);
        end
        last_good = 8'h96;
        repeat (UCB) @(negedge clock);

        // Glitch shorter than half a bit is rejected
        evq.delete();
        rx = 1'b0;
        repeat (6) @(negedge clock);
        rx = 1'b1;
        n_act = 0;
        for (int c = 0; c < 3 * UCB; c++) begin
            @(negedge clock);
            if (active) n_act++;
        end
        check("glitch_events", evq.size(), 0);
        check("glitch_active_len_ok", (n_act >= 1 && n_act <= HALF + 1), 1);
        check("glitch_active_end", active, 0);
        check("glitch_readdata", readdata, last_good);

        // 0x00 then 0xFF with no idle gap: pulses one frame apart
        evq.delete();
        send_frame(8'h00, 1'b1, UCB, miss);
        send_frame(8'hFF, 1'b1, UCB, miss);
        repeat (UCB) @(negedge clock);
        check("b2b_events", evq.size(), 2);
        if (evq.size() == 2) begin
            check("b2b_rd0", evq[0].rd, 8'h00);
            check("b2b_rd1", evq[1].rd, 8'hFF);
            dt = evq[1].t - evq[0].t - 10 * UCB;
            check("b2b_spacing_ok", (dt >= -1 && dt <= 1), 1);
        end
        last_good = 8'hFF;

        // Reset during data bit 4 of 0x5A aborts the frame silently
        evq.delete();
        begin
            logic [7:0] d;
            d = 8'h5A;
            rx = 1'b0;
            repeat (UCB) @(negedge clock);
            for (int b = 0; b < 4; b++) begin
                rx = d[b];
                repeat (UCB) @(negedge clock);
            end
            rx = d[4];
            repeat (UCB / 2) @(negedge clock);
        end
        reset = 1'b0;
        @(negedge clock);
        check("midrst_readdata", readdata, 0);
        check("midrst_done", done, 0);
        check("midrst_frame_error", frame_error, 0);
        check("midrst_active", active, 0);
        repeat (9) @(negedge clock);
        rx = 1'b1;
        reset = 1'b1;
        repeat (2 * UCB) @(negedge clock);
        check("midrst_no_events", evq.size(), 0);
        apply("resend5A", 8'h5A, 1'b1, UCB, 0, UCB, 8'h5A, 1'b0);
        last_good = 8'h5A;

        // Random frames against a frame-level reference model
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            bit         ok;
            int         per, hold, gap;
            logic [7:0] exp_rd;
            d    = 8'($urandom_range(0, 255));
            ok   = ($urandom_range(0, 4) != 0);
            per  = UCB - 1 + int'($urandom_range(0, 2));
            hold = ok ? 0 : int'($urandom_range(1, 200));
            gap  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 50)) : 0;
            exp_rd = ok ? d : last_good;
            apply($sformatf("rnd%0d", i), d, ok, per, hold, gap, exp_rd, !ok);
            if (ok) last_good = d;
        end

        check("never_done_and_ferr", both_high, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
